dmem_sram_bridge: RTL

- Memory-stage data-side bridge. Converts the datapath's M-stage access (address, byte selects, store data) into an SRAM-like req/addr_ok/data_ok bus transaction.
- Returns load data as readdataM and raises a stall request to the hazard unit until the access completes.
- Holds completed load data while the pipeline stays frozen for other reasons.
- Sits between the datapath M stage and the data bus/AXI shim.

---
 rtl/dmem_sram_bridge.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dmem_sram_bridge.sv
// M-stage data bridge: turns a CPU load/store into one SRAM-like req/addr_ok/data_ok transaction.
// Optional kseg0/kseg1 bus address folding is enabled by defining DMEM_ADDR_MAP_EN.
module dmem_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [1:0]          cpu_size,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                pipe_stall,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  // Handshake: a request is accepted on a cycle with bus_req && bus_addr_ok;
  // the accepted transaction finishes on the first later-or-same cycle with bus_data_ok.
  logic [1:0]          state_q, state_d;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   wdata_q;

  logic issue, done, is_wr;
  logic [ADDR_W-1:0]   src_addr;
  logic [DATA_W/8-1:0] src_wstrb;
  logic [DATA_W-1:0]   src_wdata;
  logic [1:0]          src_size;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
`ifdef DMEM_ADDR_MAP_EN
    if (a[ADDR_W-1 -: 2] == 2'b10) map_addr = {3'b000, a[ADDR_W-4:0]};
    else                           map_addr = a;
`else
    map_addr = a;
`endif
  endfunction

  always_comb begin
    issue   = 1'b0;
    done    = 1'b0;
    is_wr   = wr_q;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        is_wr = |cpu_wen;
        if (cpu_en) begin
          issue = 1'b1;
          if (bus_addr_ok && bus_data_ok) done = 1'b1;
          else if (bus_addr_ok)           state_d = WAIT;
          else                            state_d = REQ;
        end
      end
      REQ: begin
        // A flush before acceptance withdraws the request; nothing is outstanding yet.
        if (!cpu_en) state_d = IDLE;
        else begin
          issue = 1'b1;
          if (bus_addr_ok && bus_data_ok) done = 1'b1;
          else if (bus_addr_ok)           state_d = WAIT;
        end
      end
      WAIT: if (bus_data_ok) done = 1'b1;
      HOLD: if (!pipe_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      issue = 1'b0;
      done  = 1'b0;
    end
    if (done) state_d = pipe_stall ? HOLD : IDLE;
  end

  always_comb begin
    src_addr  = (state_q == IDLE) ? cpu_addr  : addr_q;
    src_wstrb = (state_q == IDLE) ? cpu_wen   : wstrb_q;
    src_wdata = (state_q == IDLE) ? cpu_wdata : wdata_q;
    src_size  = (state_q == IDLE) ? cpu_size  : size_q;
  end

  assign bus_req   = issue;
  assign bus_wr    = issue & is_wr;
  assign bus_size  = issue ? src_size : 2'b00;
  assign bus_addr  = issue ? map_addr(src_addr) : '0;
  assign bus_wstrb = issue ? src_wstrb : '0;
  assign bus_wdata = issue ? src_wdata : '0;
  assign cpu_stall = (issue || (state_q == WAIT && !rst)) && !done;
  assign cpu_rdata = (done && !is_wr) ? bus_rdata : rdata_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (done && !is_wr) rdata_q <= bus_rdata;
      if (state_q == IDLE && cpu_en) begin
        addr_q  <= cpu_addr;
        wr_q    <= |cpu_wen;
        size_q  <= cpu_size;
        wstrb_q <= cpu_wen;
        wdata_q <= cpu_wdata;
      end
    end
  end

endmodule
